axil_router: RTL and testbench

Parametrised AXI4-Lite 1-to-NS router between the CPU master port and the peripheral slaves (DDR, SD, Ethernet, UART, VGA, PS2). It replaces the external `select` input with address-window decoding and runs independent read and write FSMs that obey valid/ready. A decode miss is answered locally with DECERR. Per-transaction latency is fixed and one transaction per direction is in flight.

---
 rtl/axil_pkg.sv | 21 ++
 rtl/axil_addr_decode.sv | 28 ++
 rtl/axil_router.sv | 264 ++++++++++++++++++++++++++
 tb/tb_axil_router.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - shared response codes, FSM state types and default windows for the AXI4-Lite router
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int DEF_NS = 6;
  localparam int DEF_AW = 32;

  // DDR, SD, Ethernet, UART, VGA, PS2 at 256 MiB strides, slot 0 in the low word
  localparam logic [DEF_NS*DEF_AW-1:0] DEF_SLV_BASE = {
    32'h5000_0000, 32'h4000_0000, 32'h3000_0000,
    32'h2000_0000, 32'h1000_0000, 32'h0000_0000
  };
  localparam logic [DEF_NS*DEF_AW-1:0] DEF_SLV_MASK = {DEF_NS{32'hF000_0000}};

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_RESP} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP_WAIT, W_RESP} wr_state_t;

endpackage

// File: rtl/axil_addr_decode.sv
// rtl/axil_addr_decode.sv - combinational address-window decoder with lowest-index priority
module axil_addr_decode
  import axil_pkg::*;
#(
  parameter int                 NS       = DEF_NS,
  parameter int                 AW       = DEF_AW,
  parameter int                 IW       = (NS > 1) ? $clog2(NS) : 1,
  parameter logic [NS*AW-1:0]   SLV_BASE = DEF_SLV_BASE,
  parameter logic [NS*AW-1:0]   SLV_MASK = DEF_SLV_MASK
) (
  input  logic [AW-1:0] addr_i,
  output logic [IW-1:0] idx_o,
  output logic          hit_o
);

  // Scan from the top slot down so the lowest matching index is the one left standing
  always_comb begin
    idx_o = '0;
    hit_o = 1'b0;
    for (int i = NS - 1; i >= 0; i--) begin
      if ((addr_i & SLV_MASK[i*AW +: AW]) == (SLV_BASE[i*AW +: AW] & SLV_MASK[i*AW +: AW])) begin
        idx_o = IW'(i);
        hit_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axil_router.sv
// rtl/axil_router.sv - AXI4-Lite 1-to-NS router with independent read and write FSMs and local DECERR
module axil_router
  import axil_pkg::*;
#(
  parameter int               NS       = DEF_NS,
  parameter int               AW       = DEF_AW,
  parameter int               DW       = 32,
  parameter logic [NS*AW-1:0] SLV_BASE = DEF_SLV_BASE,
  parameter logic [NS*AW-1:0] SLV_MASK = DEF_SLV_MASK
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [AW-1:0]      m_araddr,
  input  logic               m_arvalid,
  output logic               m_arready,
  output logic [DW-1:0]      m_rdata,
  output logic [1:0]         m_rresp,
  output logic               m_rvalid,
  input  logic               m_rready,
  input  logic [AW-1:0]      m_awaddr,
  input  logic               m_awvalid,
  output logic               m_awready,
  input  logic [DW-1:0]      m_wdata,
  input  logic [DW/8-1:0]    m_wstrb,
  input  logic               m_wvalid,
  output logic               m_wready,
  output logic [1:0]         m_bresp,
  output logic               m_bvalid,
  input  logic               m_bready,
  output logic [AW-1:0]      s_araddr,
  output logic [NS-1:0]      s_arvalid,
  input  logic [NS-1:0]      s_arready,
  input  logic [NS*DW-1:0]   s_rdata,
  input  logic [NS*2-1:0]    s_rresp,
  input  logic [NS-1:0]      s_rvalid,
  output logic [NS-1:0]      s_rready,
  output logic [AW-1:0]      s_awaddr,
  output logic [NS-1:0]      s_awvalid,
  input  logic [NS-1:0]      s_awready,
  output logic [DW-1:0]      s_wdata,
  output logic [DW/8-1:0]    s_wstrb,
  output logic [NS-1:0]      s_wvalid,
  input  logic [NS-1:0]      s_wready,
  input  logic [NS*2-1:0]    s_bresp,
  input  logic [NS-1:0]      s_bvalid,
  output logic [NS-1:0]      s_bready
);

  localparam int IW = (NS > 1) ? $clog2(NS) : 1;

  rd_state_t         rd_state_q;
  logic [IW-1:0]     rd_idx_q;
  logic [AW-1:0]     araddr_q;
  logic [DW-1:0]     rdata_q;
  logic [1:0]        rresp_q;
  logic              arready_q, rvalid_q;
  logic [NS-1:0]     s_arvalid_q, s_rready_q;

  wr_state_t         wr_state_q;
  logic [IW-1:0]     wr_idx_q;
  logic [AW-1:0]     awaddr_q;
  logic [DW-1:0]     wdata_q;
  logic [DW/8-1:0]   wstrb_q;
  logic [1:0]        bresp_q;
  logic              awready_q, wready_q, bvalid_q, aw_held_q, w_held_q;
  logic [NS-1:0]     s_awvalid_q, s_wvalid_q, s_bready_q;

  logic [IW-1:0]     rd_dec_idx, wr_dec_idx;
  logic              rd_dec_hit, wr_dec_hit;
  logic [NS-1:0]     rd_onehot, wr_onehot;
  logic [AW-1:0]     wr_dec_addr;
  logic              aw_got, w_got;
  logic [DW-1:0]     sel_rdata;
  logic [1:0]        sel_rresp, sel_bresp;

  // The write decode sees the held AW address, or the incoming one when AW lands this cycle
  assign wr_dec_addr = aw_held_q ? awaddr_q : m_awaddr;
  assign aw_got      = aw_held_q | (awready_q & m_awvalid);
  assign w_got       = w_held_q  | (wready_q  & m_wvalid);
  assign rd_onehot   = NS'(1) << rd_dec_idx;
  assign wr_onehot   = NS'(1) << wr_dec_idx;

  axil_addr_decode #(.NS(NS), .AW(AW), .IW(IW), .SLV_BASE(SLV_BASE), .SLV_MASK(SLV_MASK)) u_rd_dec (
    .addr_i(m_araddr), .idx_o(rd_dec_idx), .hit_o(rd_dec_hit)
  );

  axil_addr_decode #(.NS(NS), .AW(AW), .IW(IW), .SLV_BASE(SLV_BASE), .SLV_MASK(SLV_MASK)) u_wr_dec (
    .addr_i(wr_dec_addr), .idx_o(wr_dec_idx), .hit_o(wr_dec_hit)
  );

  // Pick the response fields of the slave each FSM latched
  always_comb begin
    sel_rdata = '0;
    sel_rresp = '0;
    sel_bresp = '0;
    for (int i = 0; i < NS; i++) begin
      if (rd_idx_q == IW'(i)) begin
        sel_rdata = s_rdata[i*DW +: DW];
        sel_rresp = s_rresp[i*2 +: 2];
      end
      if (wr_idx_q == IW'(i)) sel_bresp = s_bresp[i*2 +: 2];
    end
  end

  // Read FSM: AR accept, slave AR, slave R capture, master R with all outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state_q  <= R_IDLE;
      rd_idx_q    <= '0;
      araddr_q    <= '0;
      rdata_q     <= '0;
      rresp_q     <= RESP_OKAY;
      arready_q   <= 1'b0;
      rvalid_q    <= 1'b0;
      s_arvalid_q <= '0;
      s_rready_q  <= '0;
    end else begin
      case (rd_state_q)
        R_IDLE: begin
          if (arready_q && m_arvalid) begin
            arready_q <= 1'b0;
            araddr_q  <= m_araddr;
            rd_idx_q  <= rd_dec_idx;
            if (rd_dec_hit) begin
              s_arvalid_q <= rd_onehot;
              rd_state_q  <= R_ADDR;
            end else begin
              rdata_q    <= '0;
              rresp_q    <= RESP_DECERR;
              rvalid_q   <= 1'b1;
              rd_state_q <= R_RESP;
            end
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_ADDR: begin
          if (|(s_arvalid_q & s_arready)) begin
            s_arvalid_q <= '0;
            s_rready_q  <= NS'(1) << rd_idx_q;
            rd_state_q  <= R_DATA;
          end
        end
        R_DATA: begin
          if (|(s_rready_q & s_rvalid)) begin
            s_rready_q <= '0;
            rdata_q    <= sel_rdata;
            rresp_q    <= sel_rresp;
            rvalid_q   <= 1'b1;
            rd_state_q <= R_RESP;
          end
        end
        R_RESP: begin
          if (m_rready) begin
            rvalid_q   <= 1'b0;
            arready_q  <= 1'b1;
            rd_state_q <= R_IDLE;
          end
        end
        default: rd_state_q <= R_IDLE;
      endcase
    end
  end

  // Write FSM: collect AW and W in any order, drive slave AW/W, capture B, return master B
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state_q  <= W_IDLE;
      wr_idx_q    <= '0;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      bresp_q     <= RESP_OKAY;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      aw_held_q   <= 1'b0;
      w_held_q    <= 1'b0;
      s_awvalid_q <= '0;
      s_wvalid_q  <= '0;
      s_bready_q  <= '0;
    end else begin
      case (wr_state_q)
        W_IDLE: begin
          if (awready_q && m_awvalid) begin
            awaddr_q  <= m_awaddr;
            aw_held_q <= 1'b1;
            awready_q <= 1'b0;
          end else if (!aw_held_q) begin
            awready_q <= 1'b1;
          end
          if (wready_q && m_wvalid) begin
            wdata_q  <= m_wdata;
            wstrb_q  <= m_wstrb;
            w_held_q <= 1'b1;
            wready_q <= 1'b0;
          end else if (!w_held_q) begin
            wready_q <= 1'b1;
          end
          if (aw_got && w_got) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            wr_idx_q  <= wr_dec_idx;
            if (wr_dec_hit) begin
              s_awvalid_q <= wr_onehot;
              s_wvalid_q  <= wr_onehot;
              wr_state_q  <= W_ADDR;
            end else begin
              bresp_q    <= RESP_DECERR;
              bvalid_q   <= 1'b1;
              wr_state_q <= W_RESP;
            end
          end
        end
        W_ADDR: begin
          s_awvalid_q <= s_awvalid_q & ~s_awready;
          s_wvalid_q  <= s_wvalid_q & ~s_wready;
          if (!(|(s_awvalid_q & ~s_awready)) && !(|(s_wvalid_q & ~s_wready))) begin
            s_bready_q <= NS'(1) << wr_idx_q;
            wr_state_q <= W_RESP_WAIT;
          end
        end
        W_RESP_WAIT: begin
          if (|(s_bready_q & s_bvalid)) begin
            s_bready_q <= '0;
            bresp_q    <= sel_bresp;
            bvalid_q   <= 1'b1;
            wr_state_q <= W_RESP;
          end
        end
        W_RESP: begin
          if (m_bready) begin
            bvalid_q   <= 1'b0;
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
            wr_state_q <= W_IDLE;
          end
        end
        default: wr_state_q <= W_IDLE;
      endcase
    end
  end

  assign m_arready = arready_q;
  assign m_rdata   = rdata_q;
  assign m_rresp   = rresp_q;
  assign m_rvalid  = rvalid_q;
  assign m_awready = awready_q;
  assign m_wready  = wready_q;
  assign m_bresp   = bresp_q;
  assign m_bvalid  = bvalid_q;
  assign s_araddr  = araddr_q;
  assign s_arvalid = s_arvalid_q;
  assign s_rready  = s_rready_q;
  assign s_awaddr  = awaddr_q;
  assign s_wdata   = wdata_q;
  assign s_wstrb   = wstrb_q;
  assign s_awvalid = s_awvalid_q;
  assign s_wvalid  = s_wvalid_q;
  assign s_bready  = s_bready_q;

endmodule

// File: tb/tb_axil_router.sv
// tb/tb_axil_router.sv - directed self-checking bench for axil_router
module tb_axil_router;
  import axil_pkg::*;

  localparam int NS = 6;
  localparam int AW = 32;
  localparam int DW = 32;
  // Slot 0 mask 0xD000_0000 makes window 0 also cover 0x2xxx_xxxx, overlapping window 2
  localparam logic [NS*AW-1:0] TB_MASK = {{5{32'hF000_0000}}, 32'hD000_0000};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [AW-1:0]    m_araddr, m_awaddr;
  logic             m_arvalid, m_arready, m_rvalid, m_rready;
  logic [DW-1:0]    m_rdata, m_wdata;
  logic [1:0]       m_rresp, m_bresp;
  logic             m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [DW/8-1:0]  m_wstrb;
  logic [AW-1:0]    s_araddr, s_awaddr;
  logic [NS-1:0]    s_arvalid, s_arready, s_rvalid, s_rready;
  logic [NS*DW-1:0] s_rdata;
  logic [NS*2-1:0]  s_rresp, s_bresp;
  logic [NS-1:0]    s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [DW-1:0]    s_wdata;
  logic [DW/8-1:0]  s_wstrb;

  axil_router #(.NS(NS), .AW(AW), .DW(DW), .SLV_BASE(DEF_SLV_BASE), .SLV_MASK(TB_MASK)) dut (
    .clk(clk), .rst(rst),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int vld_cnt  = 0;
  int ar_cnt [NS];
  int rd_wait [NS];
  int rcnt [NS];
  int aw_cyc, w_cyc;
  logic [NS-1:0]   aw_seen, w_seen;
  logic [AW-1:0]   got_awaddr;
  logic [DW-1:0]   got_wdata;
  logic [DW/8-1:0] got_wstrb;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Activity monitor
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < NS; i++) if (s_arvalid[i]) ar_cnt[i] <= ar_cnt[i] + 1;
    if (|{s_arvalid, s_awvalid, s_wvalid}) vld_cnt <= vld_cnt + 1;
  end

  // Slave models: R after rd_wait cycles, B one cycle after both AW and W
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_rvalid <= '0;
      s_bvalid <= '0;
      aw_seen  <= '0;
      w_seen   <= '0;
      for (int i = 0; i < NS; i++) rcnt[i] <= 0;
    end else begin
      for (int i = 0; i < NS; i++) begin
        if (s_arvalid[i] && s_arready[i]) begin
          if (rd_wait[i] == 0) s_rvalid[i] <= 1'b1;
          else rcnt[i] <= rd_wait[i];
        end else if (rcnt[i] != 0) begin
          rcnt[i] <= rcnt[i] - 1;
          if (rcnt[i] == 1) s_rvalid[i] <= 1'b1;
        end
        if (s_rvalid[i] && s_rready[i]) s_rvalid[i] <= 1'b0;
        if (s_awvalid[i] && s_awready[i]) begin
          aw_seen[i] <= 1'b1;
          got_awaddr <= s_awaddr;
          aw_cyc     <= cyc;
        end
        if (s_wvalid[i] && s_wready[i]) begin
          w_seen[i] <= 1'b1;
          got_wdata <= s_wdata;
          got_wstrb <= s_wstrb;
          w_cyc     <= cyc;
        end
        if ((aw_seen[i] || (s_awvalid[i] && s_awready[i])) && (w_seen[i] || (s_wvalid[i] && s_wready[i]))) begin
          s_bvalid[i] <= 1'b1;
          aw_seen[i]  <= 1'b0;
          w_seen[i]   <= 1'b0;
        end
        if (s_bvalid[i] && s_bready[i]) s_bvalid[i] <= 1'b0;
      end
    end
  end

  task automatic rd(input logic [31:0] a, input int hold, output logic [31:0] d,
                    output logic [1:0] r, output int lat, output logic stable);
    int n;
    n = 0;
    @(negedge clk);
    while (!m_arready && n < 20) begin @(negedge clk); n++; end
    m_araddr = a; m_arvalid = 1'b1;
    @(negedge clk);
    m_arvalid = 1'b0;
    lat = 1;
    while (!m_rvalid && lat < 40) begin @(negedge clk); lat++; end
    d = m_rdata; r = m_rresp; stable = 1'b1;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      if (!m_rvalid || m_rdata !== d || m_rresp !== r || m_arready) stable = 1'b0;
    end
    m_rready = 1'b1;
    @(negedge clk);
    m_rready = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    input int lead, output logic [1:0] r, output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!(m_awready && m_wready) && n < 20) begin @(negedge clk); n++; end
    m_wdata = d; m_wstrb = s; m_wvalid = 1'b1;
    if (lead > 0) begin
      @(negedge clk);
      m_wvalid = 1'b0;
      repeat (lead - 1) @(negedge clk);
    end
    m_awaddr = a; m_awvalid = 1'b1;
    @(negedge clk);
    m_awvalid = 1'b0; m_wvalid = 1'b0;
    lat = 1;
    while (!m_bvalid && lat < 40) begin @(negedge clk); lat++; end
    r = m_bresp;
    m_bready = 1'b1;
    @(negedge clk);
    m_bready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int          lat, snap0, snap2, snap3, tot;
    logic        st;

    rst = 1'b1;
    m_araddr = '0; m_arvalid = 1'b0; m_rready = 1'b0;
    m_awaddr = '0; m_awvalid = 1'b0; m_wdata = '0; m_wstrb = '0; m_wvalid = 1'b0; m_bready = 1'b0;
    s_arready = '1; s_awready = '1; s_wready = '1;
    s_rdata = {32'h5555_0005, 32'h4444_0004, 32'hDEAD_BEEF, 32'h2222_0002, 32'h1111_0001, 32'h0000_C0DE};
    s_rresp = {RESP_SLVERR, RESP_OKAY, RESP_OKAY, RESP_OKAY, RESP_OKAY, RESP_OKAY};
    s_bresp = {RESP_OKAY, RESP_OKAY, RESP_OKAY, RESP_OKAY, RESP_SLVERR, RESP_OKAY};
    for (int i = 0; i < NS; i++) rd_wait[i] = 0;
    rd_wait[3] = 2;

    repeat (3) @(negedge clk);
    check("rst_m_ready", {m_arready, m_awready, m_wready}, 3'b000);
    check("rst_m_valid", {m_rvalid, m_bvalid}, 2'b00);
    check("rst_s_vr", {s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready}, '0);
    check("rst_regs", {m_rdata, s_araddr}, '0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_release", {m_arready, m_awready, m_wready}, 3'b111);

    // Read hit on slave 3 with 2 wait cycles
    snap3 = ar_cnt[3];
    tot = 0; for (int i = 0; i < NS; i++) tot += ar_cnt[i];
    rd(32'h3000_0010, 0, d, r, lat, st);
    check("rd3_data", d, 32'hDEAD_BEEF);
    check("rd3_resp", r, RESP_OKAY);
    check("rd3_lat", lat, 5);
    check("rd3_araddr", s_araddr, 32'h3000_0010);
    check("rd3_arvalid_cycles", ar_cnt[3] - snap3, 1);
    for (int i = 0; i < NS; i++) tot -= ar_cnt[i];
    check("rd3_only_slave3", -tot, 1);

    // Zero-wait read, slave error forwarded
    rd(32'h5000_0004, 0, d, r, lat, st);
    check("rd5_data", d, 32'h5555_0005);
    check("rd5_resp", r, RESP_SLVERR);
    check("rd5_lat", lat, 3);

    // W two cycles before AW, slave 1
    wr(32'h1000_0004, 32'hA5A5_A5A5, 4'b0101, 2, r, lat);
    check("w1_bresp", r, RESP_SLVERR);
    check("w1_lat", lat, 3);
    check("w1_awaddr", got_awaddr, 32'h1000_0004);
    check("w1_wdata", got_wdata, 32'hA5A5_A5A5);
    check("w1_wstrb", got_wstrb, 4'b0101);
    check("w1_together", aw_cyc - w_cyc, 0);

    // AW and W in the same cycle, slave 4
    wr(32'h4000_0020, 32'h1234_5678, 4'hF, 0, r, lat);
    check("w4_bresp", r, RESP_OKAY);
    check("w4_lat", lat, 3);
    check("w4_wdata", got_wdata, 32'h1234_5678);

    // Decode miss in both directions
    snap0 = vld_cnt;
    rd(32'hF000_0000, 0, d, r, lat, st);
    check("miss_rd_resp", r, RESP_DECERR);
    check("miss_rd_data", d, 32'h0);
    check("miss_rd_lat", lat, 1);
    wr(32'hF000_0000, 32'hFFFF_FFFF, 4'hF, 0, r, lat);
    check("miss_wr_resp", r, RESP_DECERR);
    check("miss_wr_lat", lat, 1);
    check("miss_no_slave_valid", vld_cnt - snap0, 0);

    // Overlapping windows 0 and 2: slot 0 wins
    snap0 = ar_cnt[0]; snap2 = ar_cnt[2];
    rd(32'h2000_0008, 0, d, r, lat, st);
    check("ovl_data", d, 32'h0000_C0DE);
    check("ovl_slave0", ar_cnt[0] - snap0, 1);
    check("ovl_slave2_idle", ar_cnt[2] - snap2, 0);

    // Back-pressure on R
    rd(32'h5000_0000, 5, d, r, lat, st);
    check("bp_stable", st, 1'b1);
    check("bp_data", d, 32'h5555_0005);

    // Reset while read is in R_DATA and write is in W_ADDR
    rd_wait[5] = 20;
    s_awready = '0;
    @(negedge clk);
    m_araddr = 32'h5000_0000; m_arvalid = 1'b1;
    m_awaddr = 32'h4000_0000; m_awvalid = 1'b1;
    m_wdata = 32'hCAFE_F00D; m_wstrb = 4'hF; m_wvalid = 1'b1;
    @(negedge clk);
    m_arvalid = 1'b0; m_awvalid = 1'b0; m_wvalid = 1'b0;
    @(negedge clk);
    check("pre_rst_state", {s_rready[5], s_awvalid[4]}, 2'b11);
    rst = 1'b1;
    #1;
    check("rst_mid_drop", {s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready, m_rvalid, m_bvalid}, '0);
    check("rst_mid_ready", {m_arready, m_awready, m_wready}, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    s_awready = '1;
    rd_wait[5] = 0;
    rd(32'h5000_0008, 0, d, r, lat, st);
    check("post_rst_rd_data", d, 32'h5555_0005);
    check("post_rst_rd_lat", lat, 3);
    wr(32'h4000_0000, 32'h0BAD_CAFE, 4'b0011, 0, r, lat);
    check("post_rst_wr", {r, got_wdata, got_wstrb}, {RESP_OKAY, 32'h0BAD_CAFE, 4'b0011});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
